// File: rtl/riscv_pkg.sv
// Shared definitions for the memory/writeback pipeline stage.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF / MADDR_W_DEF  default data, register-address
//                                          and byte-address widths
//   dmem_state_e                           data-memory controller FSM states
package riscv_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int MADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the MEM/WB stage.
// Owns the IDLE/REQ/WAIT handshake FSM, the registers that capture a memory
// instruction when it is accepted, and the upstream stall.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   valid_i               EXE presents an instruction
//   mem_we_i, mem2rf_i    store / load flags
//   alu_result_i          ALU result (low MADDR_W bits are the byte address)
//   store_data_i          store data
//   rf_waddr_i            destination register
//   dmem_gnt_i            request accepted
//   dmem_rvalid_i         load data valid
//   stall_o               hold upstream pipeline latches
//   dmem_req_o/we_o/addr_o/wdata_o   memory request
//   idle_o                controller is idle (non-memory writeback allowed)
//   load_done_o           load data is arriving this cycle
//   cap_waddr_o           destination register of the captured instruction
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MADDR_W = MADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               mem_we_i,
  input  logic               mem2rf_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic [DATA_W-1:0]  store_data_i,
  input  logic [ADDR_W-1:0]  rf_waddr_i,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  output logic               stall_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [MADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  output logic               idle_o,
  output logic               load_done_o,
  output logic [ADDR_W-1:0]  cap_waddr_o
);

  dmem_state_e        state_q, state_d;
  logic [MADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               store_q, store_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;

  logic access;
  logic in_idle, in_req, in_wait;

  assign access  = valid_i & (mem_we_i | mem2rf_i);
  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    store_d = store_q;
    waddr_d = waddr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d = ST_REQ;
          // Word-only access: the address is passed through untouched.
          addr_d  = alu_result_i[MADDR_W-1:0];
          wdata_d = store_data_i;
          // A store wins when both flags are set.
          store_d = mem_we_i;
          waddr_d = rf_waddr_i;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          state_d = store_q ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      waddr_q <= waddr_d;
    end
  end

  // Upstream advances only on the edge that completes the access. Gated by
  // reset so nothing upstream is held while the stage is being cleared.
  assign stall_o = reset & ((in_idle & access)
                         | (in_req  & ~(store_q & dmem_gnt_i))
                         | (in_wait & ~dmem_rvalid_i));

  assign dmem_req_o   = in_req;
  assign dmem_we_o    = store_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

  assign idle_o      = in_idle;
  assign load_done_o = in_wait & dmem_rvalid_i;
  assign cap_waddr_o = waddr_q;

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: issues data-memory accesses for loads and stores and
// drives the register-file write port back to the decode stage.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   valid_i                          EXE presents an instruction
//   alu_result_i, store_data_i       ALU result / address, store data
//   rf_waddr_i, rf_we_i              destination register and write flag
//   mem_we_i, mem2rf_i               store / load flags
//   stall_o                          hold FE/DE/EXE latches
//   dmem_req_o, dmem_we_o            memory request, request is a store
//   dmem_addr_o, dmem_wdata_o        request address and store data
//   dmem_gnt_i, dmem_rvalid_i        request accepted, load data valid
//   dmem_rdata_i                     load data
//   rf_waddr_o, rf_wdata_o, rf_we_o  register-file write port
module memwb_stage
  import riscv_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MADDR_W = MADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic [DATA_W-1:0]  store_data_i,
  input  logic [ADDR_W-1:0]  rf_waddr_i,
  input  logic               rf_we_i,
  input  logic               mem_we_i,
  input  logic               mem2rf_i,
  output logic               stall_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [MADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic [ADDR_W-1:0]  rf_waddr_o,
  output logic [DATA_W-1:0]  rf_wdata_o,
  output logic               rf_we_o
);

  logic              idle;
  logic              load_done;
  logic [ADDR_W-1:0] cap_waddr;

  dmem_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MADDR_W (MADDR_W)
  ) u_dmem_ctrl (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .mem_we_i      (mem_we_i),
    .mem2rf_i      (mem2rf_i),
    .alu_result_i  (alu_result_i),
    .store_data_i  (store_data_i),
    .rf_waddr_i    (rf_waddr_i),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .idle_o        (idle),
    .load_done_o   (load_done),
    .cap_waddr_o   (cap_waddr)
  );

  logic              we_q,    we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic alu_wr;
  logic ld_wr;

  // Non-memory instructions write back only when the controller is idle;
  // otherwise valid_i belongs to an instruction still held by the stall.
  // Writes to register 0 are dropped entirely so the port keeps its last value.
  assign alu_wr = idle & valid_i & ~(mem_we_i | mem2rf_i) & rf_we_i
                & (rf_waddr_i != '0);
  assign ld_wr  = load_done & (cap_waddr != '0);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (ld_wr) begin
      we_d    = 1'b1;
      waddr_d = cap_waddr;
      wdata_d = dmem_rdata_i;
    end else if (alu_wr) begin
      we_d    = 1'b1;
      waddr_d = rf_waddr_i;
      wdata_d = alu_result_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 32;

  logic          clk;
  logic          reset;
  logic          valid_i;
  logic [DW-1:0] alu_result_i;
  logic [DW-1:0] store_data_i;
  logic [AW-1:0] rf_waddr_i;
  logic          rf_we_i;
  logic          mem_we_i;
  logic          mem2rf_i;
  logic          stall_o;
  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [MW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_gnt_i;
  logic          dmem_rvalid_i;
  logic [DW-1:0] dmem_rdata_i;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o;

  memwb_stage #(.DATA_W(DW), .ADDR_W(AW), .MADDR_W(MW)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .alu_result_i  (alu_result_i),
    .store_data_i  (store_data_i),
    .rf_waddr_i    (rf_waddr_i),
    .rf_we_i       (rf_we_i),
    .mem_we_i      (mem_we_i),
    .mem2rf_i      (mem2rf_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_we_o       (rf_we_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          vld;
    logic          st;
    logic          ld;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
  } instr_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   noise_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Writeback monitor: every rf_we_o pulse must match the oldest expected
  // write, at the expected cycle; between pulses the port must hold.
  initial begin : monitor
    logic          rs;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    exp_t          e;
    last_a = '0;
    last_d = '0;
    forever begin
      @(posedge clk);
      rs = reset;
      @(negedge clk);
      if (!rs) begin
        chk("rst_rf_we", 32'(rf_we_o), 32'h0);
        chk("rst_rf_waddr", 32'(rf_waddr_o), 32'h0);
        chk("rst_rf_wdata", rf_wdata_o, 32'h0);
        last_a = '0;
        last_d = '0;
      end else if (rf_we_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual=%h:%h expected=no write (cycle %0d)",
                   rf_waddr_o, rf_wdata_o, cyc);
        end else begin
          e = q.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.cyc));
          chk("wb_addr", 32'(rf_waddr_o), 32'(e.wa));
          chk("wb_data", rf_wdata_o, e.d);
        end
        last_a = rf_waddr_o;
        last_d = rf_wdata_o;
      end else begin
        chk("wb_we_known", 32'(rf_we_o), 32'h0);
        chk("hold_addr", 32'(rf_waddr_o), 32'(last_a));
        chk("hold_data", rf_wdata_o, last_d);
      end
    end
  end

  // One instruction from EXE plus the memory's responses to it, cycle by
  // cycle, until the stage lets the upstream advance. gd = cycles REQ waits
  // before gnt, rd = cycles WAIT lasts before rvalid, rdat = load data.
  task automatic run_instr(input instr_t ins, input int gd_in, input int rd_in,
                           input logic [DW-1:0] rdat);
    int   gd, rd, guard;
    bit   first, granted, done, is_mem, is_st, exp_req, exp_stall, comp;
    logic g, rv;
    gd = gd_in; rd = rd_in; guard = 0;
    first = 1'b1; granted = 1'b0; done = 1'b0;
    is_mem = ins.vld && (ins.st || ins.ld);
    is_st  = ins.st;
    while (!done) begin
      @(negedge clk);
      if (first || !noise_en) begin
        valid_i      = ins.vld;
        mem_we_i     = ins.st;
        mem2rf_i     = ins.ld;
        rf_we_i      = ins.we;
        rf_waddr_i   = ins.wa;
        alu_result_i = ins.alu;
        store_data_i = ins.sd;
      end else begin
        // Inputs must be ignored once the instruction has been captured.
        valid_i      = 1'($urandom_range(0, 1));
        mem_we_i     = 1'($urandom_range(0, 1));
        mem2rf_i     = 1'($urandom_range(0, 1));
        rf_we_i      = 1'($urandom_range(0, 1));
        rf_waddr_i   = AW'($urandom);
        alu_result_i = $urandom;
        store_data_i = $urandom;
      end
      exp_req = is_mem && !first && !granted;
      chk("dmem_req", 32'(dmem_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_addr", dmem_addr_o, ins.alu);
        chk("dmem_we", 32'(dmem_we_o), 32'(is_st));
        if (is_st) chk("dmem_wdata", dmem_wdata_o, ins.sd);
      end
      comp = 1'b0; g = 1'b0; rv = 1'b0;
      if (exp_req) begin
        if (gd == 0) begin
          g = 1'b1;
          if (is_st) comp = 1'b1;
        end else gd--;
      end else if (noise_en) g = ($urandom_range(0, 3) == 0);
      if (is_mem && !is_st && granted) begin
        if (rd == 0) begin
          rv = 1'b1;
          comp = 1'b1;
        end else rd--;
      end else if (noise_en) rv = ($urandom_range(0, 3) == 0);
      dmem_gnt_i    = g;
      dmem_rvalid_i = rv;
      dmem_rdata_i  = rv ? rdat : $urandom;
      exp_stall = is_mem && !comp;
      #1;
      chk("stall", 32'(stall_o), 32'(exp_stall));
      if (ins.vld && !is_mem && ins.we && ins.wa != '0)
        q.push_back('{cyc: cyc + 1, wa: ins.wa, d: ins.alu});
      if (is_mem && !is_st && comp && ins.wa != '0)
        q.push_back('{cyc: cyc + 1, wa: ins.wa, d: rdat});
      if (exp_req && g) granted = 1'b1;
      first = 1'b0;
      done  = !exp_stall;
      guard++;
      if (!done && guard > 40) begin
        checks++;
        failures++;
        $display("FAIL instr_timeout actual=%0d cycles expected=<=40", guard);
        done = 1'b1;
      end
    end
  endtask

  task automatic gen(output instr_t r);
    int k;
    k      = $urandom_range(0, 9);
    r.vld  = ($urandom_range(0, 7) != 0);
    r.st   = (k >= 7);
    r.ld   = (k >= 4 && k <= 6) || (k == 9);
    r.we   = 1'($urandom_range(0, 1));
    r.wa   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
    r.alu  = $urandom;
    r.sd   = $urandom;
  endtask

  task automatic mk(output instr_t r, input logic st, input logic ld, input logic we,
                    input logic [AW-1:0] wa, input logic [DW-1:0] alu, input logic [DW-1:0] sd);
    r.vld = 1'b1; r.st = st; r.ld = ld; r.we = we; r.wa = wa; r.alu = alu; r.sd = sd;
  endtask

  task automatic bubbles(input int n);
    instr_t b;
    mk(b, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    b.vld = 1'b0;
    for (int i = 0; i < n; i++) run_instr(b, 0, 0, '0);
  endtask

  initial begin : driver
    instr_t ins;
    reset = 1'b0; valid_i = 1'b0; alu_result_i = '0; store_data_i = '0;
    rf_waddr_i = '0; rf_we_i = 1'b0; mem_we_i = 1'b0; mem2rf_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_req", 32'(dmem_req_o), 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    reset = 1'b1;

    // Directed cases.
    mk(ins, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);            // ALU write
    run_instr(ins, 0, 0, '0);
    mk(ins, 1'b1, 1'b0, 1'b1, 5'd3, 32'h40, 32'hDEADBEEF);       // store, gnt late
    run_instr(ins, 3, 0, '0);
    mk(ins, 1'b0, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0);             // load
    run_instr(ins, 0, 2, 32'hCAFEF00D);
    mk(ins, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0);        // write to x0
    run_instr(ins, 0, 0, '0);
    mk(ins, 1'b0, 1'b1, 1'b1, 5'd12, 32'h204, 32'h0);            // load then ALU
    run_instr(ins, 1, 0, 32'h0BADF00D);
    mk(ins, 1'b0, 1'b0, 1'b1, 5'd13, 32'h5555AAAA, 32'h0);
    run_instr(ins, 0, 0, '0);
    mk(ins, 1'b1, 1'b1, 1'b1, 5'd9, 32'h80, 32'h12345678);       // both flags: store
    run_instr(ins, 0, 0, 32'h77777777);
    bubbles(2);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      gen(ins);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    bubbles(3);
    chk("sb_drain", 32'(q.size()), 32'h0);

    // Reset in the middle of a load's WAIT with rvalid pending.
    noise_en = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; mem2rf_i = 1'b1; mem_we_i = 1'b0; rf_we_i = 1'b1;
    rf_waddr_i = 5'd9; alu_result_i = 32'h80; store_data_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("rw_req_idle", 32'(dmem_req_o), 32'h0);
    @(negedge clk);
    chk("rw_req", 32'(dmem_req_o), 32'h1);
    dmem_gnt_i = 1'b1;
    #1 chk("rw_stall_req", 32'(stall_o), 32'h1);
    @(negedge clk);
    chk("rw_req_wait", 32'(dmem_req_o), 32'h0);
    dmem_gnt_i = 1'b0;
    #1 chk("rw_stall_wait", 32'(stall_o), 32'h1);
    reset = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFEEDFACE; valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rw_req_after", 32'(dmem_req_o), 32'h0);
    chk("rw_addr_after", dmem_addr_o, 32'h0);
    chk("rw_wdata_after", dmem_wdata_o, 32'h0);
    chk("rw_we_after", 32'(dmem_we_o), 32'h0);
    #1 chk("rw_stall_after", 32'(stall_o), 32'h0);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("rw_req_idle2", 32'(dmem_req_o), 32'h0);
    #1 chk("rw_stall_idle2", 32'(stall_o), 32'h0);
    bubbles(3);

    mk(ins, 1'b0, 1'b0, 1'b1, 5'd21, 32'h0F0F0F0F, 32'h0);
    run_instr(ins, 0, 0, '0);
    bubbles(3);
    chk("sb_final", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
